// File: rtl/pulse_to_level_if.sv
// pulse_to_level_if
//   Bundles the pulse input, mode select and level/status outputs of
//   pulse_to_level.
//   master : pulse source / consumer side (drives pulseIn, mode)
//   slave  : pulse_to_level itself (drives levelOut, busy, dropped, state)
interface pulse_to_level_if;
  logic       pulseIn;
  logic       mode;
  logic       levelOut;
  logic       busy;
  logic       dropped;
  logic [1:0] state;

  modport master (
    output pulseIn,
    output mode,
    input  levelOut,
    input  busy,
    input  dropped,
    input  state
  );

  modport slave (
    input  pulseIn,
    input  mode,
    output levelOut,
    output busy,
    output dropped,
    output state
  );
endinterface

// File: rtl/pulse_to_level.sv
// pulse_to_level
//   Turns single-cycle pulses back into a held level. In STRETCH mode an
//   accepted pulse holds levelOut high for HOLD_CYCLES cycles; in TOGGLE mode
//   each accepted pulse flips levelOut. After an active period or a toggle a
//   GAP window rejects further pulses, and each rejection raises dropped for
//   one cycle.
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   io     : slave side of pulse_to_level_if
//            pulseIn (in), mode (in, 0=STRETCH 1=TOGGLE, captured in IDLE),
//            levelOut (out), busy (out), dropped (out), state[1:0] (out)
//
// state  | meaning
// IDLE   | waiting for a pulse; mode is captured here
// ACTIVE | STRETCH hold period running, cnt counts down to 0
// GAP    | rejection window, cnt counts down to 0
// 2'b11  | illegal, recovers to IDLE
module pulse_to_level #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8,
  parameter int RETRIGGER   = 1
) (
  input logic             clk,
  input logic             reset,
  pulse_to_level_if.slave io
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    GAP    = 2'b10
  } state_t;

  // Reload values are the period minus one because the loading edge itself
  // is the first cycle of the period.
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tog_q, tog_d;
  logic             mode_q;
  logic             drop_q, drop_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      mode_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      drop_q  <= drop_d;
      // mode is only allowed to change the output behaviour between events
      if (state_q == IDLE) begin
        mode_q <= io.mode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.pulseIn) begin
          if (!io.mode) begin
            state_d = ACTIVE;
            cnt_d   = HOLD_LD;
          end else begin
            tog_d = ~tog_q;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              cnt_d   = GAP_LD;
            end
          end
        end
      end
      ACTIVE: begin
        // a retrigger takes priority over expiry, even on the cnt==0 cycle
        if (io.pulseIn && (RETRIGGER != 0)) begin
          cnt_d = HOLD_LD;
        end else begin
          drop_d = io.pulseIn;
          if (cnt_q == '0) begin
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              cnt_d   = GAP_LD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      GAP: begin
        drop_d = io.pulseIn;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered sources only: no combinational path from pulseIn or mode.
  assign io.levelOut = mode_q ? tog_q : (state_q == ACTIVE);
  assign io.busy     = (state_q != IDLE);
  assign io.dropped  = drop_q;
  assign io.state    = state_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// tb_pulse_to_level
//   Directed bench for pulse_to_level. Three instances cover the parameter
//   sets of interest:
//     u0 : HOLD=8 GAP=2 RETRIGGER=1
//     u1 : HOLD=8 GAP=2 RETRIGGER=0
//     u2 : HOLD=1 GAP=0 RETRIGGER=1
//   Each step string holds one character per clock edge: the pulse and mode
//   applied for that edge, then the expected state (I/A/G), levelOut and
//   dropped after it. busy is expected high whenever the state is not I.
module tb_pulse_to_level;
  logic clk;
  logic reset;
  logic p [3];
  logic m [3];
  int   ncmp;
  int   nerr;

  pulse_to_level_if ia ();
  pulse_to_level_if ib ();
  pulse_to_level_if ic ();

  assign ia.pulseIn = p[0];
  assign ia.mode    = m[0];
  assign ib.pulseIn = p[1];
  assign ib.mode    = m[1];
  assign ic.pulseIn = p[2];
  assign ic.mode    = m[2];

  pulse_to_level #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .CNT_W(8), .RETRIGGER(1))
    u0 (.clk(clk), .reset(reset), .io(ia));
  pulse_to_level #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .CNT_W(8), .RETRIGGER(0))
    u1 (.clk(clk), .reset(reset), .io(ib));
  pulse_to_level #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8), .RETRIGGER(1))
    u2 (.clk(clk), .reset(reset), .io(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state[1:0], levelOut, busy, dropped}
  function automatic logic [4:0] obs(input int d);
    case (d)
      0:       obs = {ia.state, ia.levelOut, ia.busy, ia.dropped};
      1:       obs = {ib.state, ib.levelOut, ib.busy, ib.dropped};
      default: obs = {ic.state, ic.levelOut, ic.busy, ic.dropped};
    endcase
  endfunction

  function automatic logic [1:0] scode(input byte c);
    case (c)
      "A":     scode = 2'b01;
      "G":     scode = 2'b10;
      default: scode = 2'b00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [4:0] got,
                     input logic [4:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] got=%b exp=%b (state,level,busy,dropped)", tag, idx, got, exp);
    end
  endtask

  task automatic play(input string tag, input int d, input string pul,
                      input string mod, input string st, input string lv,
                      input string dr);
    logic [4:0] exp;
    for (int i = 0; i < pul.len(); i++) begin
      p[d] = (pul[i] == "1");
      m[d] = (mod.len() > i) && (mod[i] == "1");
      tick();
      exp = {scode(st[i]), lv[i] == "1", st[i] != "I", dr[i] == "1"};
      chk(tag, i, obs(d), exp);
    end
    p[d] = 1'b0;
  endtask

  initial begin
    ncmp  = 0;
    nerr  = 0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p[k] = 1'b0;
      m[k] = 1'b0;
    end
    #12;
    chk("rst_u0", 0, obs(0), 5'b00000);
    chk("rst_u1", 0, obs(1), 5'b00000);
    chk("rst_u2", 0, obs(2), 5'b00000);
    reset = 1'b0;

    // T1: one pulse -> 8 cycles high, 2 GAP cycles, then IDLE
    play("t1_stretch", 0, "1000000000000", "",
         "AAAAAAAAGGIII", "1111111100000", "0000000000000");

    // T2: retrigger 5 edges in extends the hold to 13 cycles
    play("t2_retrig", 0, "100001000000000000", "",
         "AAAAAAAAAAAAAGGIII", "111111111111100000", "000000000000000000");

    // T2: retrigger on the cnt==0 edge wins over expiry
    play("t2_retrig_cnt0", 0, "10000000100000000000", "",
         "AAAAAAAAAAAAAAAAGGII", "11111111111111110000", "00000000000000000000");

    // T3: no retrigger; pulse in ACTIVE, on the expiry edge and on the last GAP edge are dropped
    play("t3_noretrig", 1, "1000100010100", "",
         "AAAAAAAAGGIII", "1111111100000", "0000100010100");

    // T4: toggle, pulse in GAP dropped, mode change during GAP ignored
    play("t4_toggle", 0, "11001000", "10011111",
         "GGIIGGII", "11110000", "01000000");

    // T5: reset mid-ACTIVE (cnt=4) clears outputs without a clock edge
    play("t5_pre", 0, "1000", "", "AAAA", "1111", "0000");
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_rst", 0, obs(0), 5'b00000);
    #1;
    reset = 1'b0;
    play("t5_post", 0, "1000000000000", "",
         "AAAAAAAAGGIII", "1111111100000", "0000000000000");

    // T6: HOLD=1, GAP=0
    play("t6_isolated", 2, "10100", "", "AIAII", "10100", "00000");
    play("t6_merged", 2, "11100", "", "AAAII", "11100", "00000");
    play("t6_toggle_nogap", 2, "110", "111", "III", "100", "000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
